// File: rtl/led_pattern_ram_loader_if.sv
// Bundle of the load handshake, status flags and read port of the
// LED segment-pattern table loader.
// Load handshake: a word moves on a rising clock edge where wr_valid and
// wr_ready are both high. wr_data must be stable while wr_valid is high.
// wr_ready does not depend on wr_valid.
interface led_pattern_ram_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 7
);
    logic                  start;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  busy;
    logic                  done_tick;
    logic                  loaded;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            state_dbg;

    modport slave (
        input  start, wr_valid, wr_data, rd_addr,
        output wr_ready, busy, done_tick, loaded, rd_data, state_dbg
    );

    modport master (
        output start, wr_valid, wr_data, rd_addr,
        input  wr_ready, busy, done_tick, loaded, rd_data, state_dbg
    );
endinterface

// File: rtl/led_pattern_ram_loader.sv
// Runtime loader for the 16-entry seven-segment pattern table. A start pulse
// opens a load window, DEPTH words are written in address order, and the
// table is then flagged loaded. The read port is registered (one cycle),
// read-before-write on a same-address collision.
module led_pattern_ram_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    led_pattern_ram_loader_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  loaded_q, loaded_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  we;
    logic                  wr_ready;
    logic                  busy;
    logic                  done_tick;

    // Control registers: FSM state, load address and the loaded flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
        end
    end

    // Next-state, address advance and handshake outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        loaded_d  = loaded_q;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        done_tick = 1'b0;
        we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = LOAD;
                    addr_d   = '0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (bus.wr_valid) begin
                    we     = 1'b1;
                    // Wraps back to 0 on the final write.
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_tick = 1'b1;
                loaded_d  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pattern storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr_q] <= bus.wr_data;
        end
    end

    // Registered read port, sampled before any same-cycle write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = busy;
    assign bus.done_tick = done_tick;
    assign bus.loaded    = loaded_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_led_pattern_ram_loader.sv
// Directed-plus-random bench for the LED pattern table loader. The expected
// table is the stream of words the bench has pushed through complete or
// partial loads, addressed by their position in the load.
module tb_led_pattern_ram_loader;
    localparam int AW    = 4;
    localparam int DW    = 7;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    led_pattern_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    led_pattern_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_ram [DEPTH];
    bit            known   [DEPTH];
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done_tick === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read a sequence of addresses back-to-back and compare against the model.
    task automatic read_all(input string tag, input int n);
        logic [DW-1:0] e;
        int a;
        for (int k = 0; k < n; k++) begin
            a = (k < DEPTH) ? k : int'($urandom_range(0, DEPTH - 1));
            bus.rd_addr = AW'(a);
            if (known[a]) exp_q.push_back(exp_ram[a]);
            tick();
            if (known[a]) begin
                e = exp_q.pop_front();
                check($sformatf("%s_rd%0d", tag, a), 32'(bus.rd_data), 32'(e));
            end
        end
    endtask

    // One load sequence. gap_at/start_at/reset_at/rbw_at < 0 disables that feature.
    task automatic load(input string tag, input logic [DW-1:0] w [DEPTH],
                        input int gap_at, input int gap_len, input int start_at,
                        input int reset_at, input int rbw_at);
        int base_done;
        int start_cyc;
        int k;
        int extra;
        base_done = done_cnt;
        extra = (gap_at >= 0) ? gap_len : 0;
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
        check({tag, "_loaded_drop"}, 32'(bus.loaded), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == reset_at) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = w[i];
                #1 reset_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
                check({tag, "_rst_loaded"}, 32'(bus.loaded), 32'd0);
                check({tag, "_rst_ready"}, 32'(bus.wr_ready), 32'd0);
                bus.wr_valid = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
                tick();
                return;
            end
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.wr_valid = 1'b0;
                    bus.wr_data  = DW'($urandom);
                    tick();
                    check({tag, "_gap_ready"}, 32'(bus.wr_ready), 32'd1);
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = w[i];
            if (i == start_at) bus.start = 1'b1;
            if (i == rbw_at) bus.rd_addr = AW'(i);
            tick();
            bus.start = 1'b0;
            if (i == rbw_at) check({tag, "_rbw_old"}, 32'(bus.rd_data), 32'(exp_ram[i]));
            exp_ram[i] = w[i];
            known[i]   = 1'b1;
            if (rbw_at >= 0 && i == rbw_at + 1)
                check({tag, "_rbw_new"}, 32'(bus.rd_data), 32'(exp_ram[rbw_at]));
        end
        bus.wr_valid = 1'b0;
        k = 0;
        while (bus.done_tick !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(bus.done_tick), 32'd1);
        check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(DEPTH + 1 + extra));
        check({tag, "_done_ready"}, 32'(bus.wr_ready), 32'd0);
        tick();
        tick();
        check({tag, "_loaded"}, 32'(bus.loaded), 32'd1);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_once"}, 32'(done_cnt - base_done), 32'd1);
    endtask

    logic [DW-1:0] std_w [DEPTH];
    logic [DW-1:0] w2    [DEPTH];

    initial begin
        std_w = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;

        // Reset values.
        #3;
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_loaded", 32'(bus.loaded), 32'd0);
        check("rst_done", 32'(bus.done_tick), 32'd0);
        #20 reset_n = 1'b1;
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = AW'(a);
            tick();
            check("idle_loaded", 32'(bus.loaded), 32'd0);
            check("idle_ready", 32'(bus.wr_ready), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Back-to-back load of the standard digit patterns.
        load("std", std_w, -1, 0, -1, -1, -1);
        bus.rd_addr = 4'd3;
        tick();
        check("std_rd3", 32'(bus.rd_data), 32'h30);
        read_all("std", 20);

        // wr_valid outside LOAD must not touch the table.
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'($urandom);
            tick();
            check("idle_wv_busy", 32'(bus.busy), 32'd0);
        end
        bus.wr_valid = 1'b0;
        read_all("idle_wv", 16);

        // Gapped load with random data; reload while loaded=1.
        for (int i = 0; i < DEPTH; i++) w2[i] = DW'($urandom);
        load("gap", w2, 7, 5, -1, -1, -1);
        read_all("gap", 20);

        // start pulsed mid-load is ignored.
        load("midstart", std_w, -1, 0, 9, -1, -1);
        read_all("midstart", 16);

        // Read-before-write on address 4.
        w2 = std_w;
        w2[4] = 7'h55;
        load("rbw", w2, -1, 0, -1, -1, 4);
        read_all("rbw", 16);

        // Reset in the middle of a load, then a fresh random load.
        for (int i = 0; i < DEPTH; i++) w2[i] = DW'($urandom);
        load("rstmid", w2, -1, 0, -1, 10, -1);
        check("rstmid_idle_loaded", 32'(bus.loaded), 32'd0);
        read_all("rstmid", 16);
        for (int i = 0; i < DEPTH; i++) w2[i] = DW'($urandom);
        load("final", w2, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)),
             int'($urandom_range(0, DEPTH - 1)), -1, -1);
        read_all("final", 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
